// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: per-source result ports on one side, the single
// register-file write port plus status on the other.
interface wb_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
);
  logic [NUM_SRC-1:0]        src_valid_i;
  logic [NUM_SRC-1:0]        src_ready_o;
  logic [NUM_SRC*ADDR_W-1:0] src_waddr_i;
  logic [NUM_SRC*DATA_W-1:0] src_wdata_i;
  logic                      flush_i;
  logic                      reg_we_o;
  logic [ADDR_W-1:0]         reg_waddr_o;
  logic [DATA_W-1:0]         reg_wdata_o;
  logic [NUM_SRC-1:0]        pend_o;
  logic                      busy_o;

  // Arbiter side
  modport slave (
    input  src_valid_i, src_waddr_i, src_wdata_i, flush_i,
    output src_ready_o, reg_we_o, reg_waddr_o, reg_wdata_o, pend_o, busy_o
  );

  // Producer / register-file side
  modport master (
    output src_valid_i, src_waddr_i, src_wdata_i, flush_i,
    input  src_ready_o, reg_we_o, reg_waddr_o, reg_wdata_o, pend_o, busy_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: NUM_SRC result producers, each buffered in its own small
// FIFO, merged onto one register-file write port by fixed-priority or
// round-robin arbitration over the FIFO heads.
module wb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int ARB_MODE   = 0
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [ADDR_W-1:0] mem_addr [NUM_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr   [NUM_SRC];
  logic [PTR_W-1:0]  rd_ptr   [NUM_SRC];
  logic [CNT_W-1:0]  count    [NUM_SRC];

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   grant;
  logic               grant_valid;
  logic               write_en;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;

  // FIFO status and push qualification; zero-address results are accepted but dropped
  always_comb begin
    full = {NUM_SRC{1'b0}};
    pend = {NUM_SRC{1'b0}};
    push = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      full[i] = (count[i] == CNT_W'(FIFO_DEPTH));
      pend[i] = (count[i] != {CNT_W{1'b0}});
      push[i] = bus.src_valid_i[i] & ~full[i] & ~bus.flush_i &
                (bus.src_waddr_i[i*ADDR_W +: ADDR_W] != {ADDR_W{1'b0}});
    end
  end

  // Pick the winning FIFO head: lowest index, or first after the RR pointer
  always_comb begin
    logic [SRC_W-1:0] idx;
    grant       = {SRC_W{1'b0}};
    grant_valid = 1'b0;
    idx         = {SRC_W{1'b0}};
    if (ARB_MODE == 0) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        grant       = (!grant_valid && pend[i]) ? SRC_W'(i) : grant;
        grant_valid = grant_valid | pend[i];
      end
    end else begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        idx         = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
        grant       = (!grant_valid && pend[idx]) ? idx : grant;
        grant_valid = grant_valid | pend[idx];
      end
    end
  end

  assign write_en = grant_valid & ~bus.flush_i;

  // The granted source pops in every cycle that writes the register file
  always_comb begin
    pop = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i] = write_en & (grant == SRC_W'(i));
    end
  end

  assign bus.src_ready_o = ~full;
  assign bus.pend_o      = pend;
  assign bus.busy_o      = |pend;
  assign bus.reg_we_o    = write_en;
  assign bus.reg_waddr_o = write_en ? mem_addr[grant][rd_ptr[grant]] : {ADDR_W{1'b0}};
  assign bus.reg_wdata_o = write_en ? mem_data[grant][rd_ptr[grant]] : {DATA_W{1'b0}};

  // FIFO storage; contents need no reset because counts gate visibility
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        mem_addr[i][wr_ptr[i]] <= bus.src_waddr_i[i*ADDR_W +: ADDR_W];
        mem_data[i][wr_ptr[i]] <= bus.src_wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO pointers and counts; flush empties every FIFO at the next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= {PTR_W{1'b0}};
        rd_ptr[i] <= {PTR_W{1'b0}};
        count[i]  <= {CNT_W{1'b0}};
      end
    end else if (bus.flush_i) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= {PTR_W{1'b0}};
        rd_ptr[i] <= {PTR_W{1'b0}};
        count[i]  <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
  end

  // Round-robin pointer follows the winner only when a write is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= SRC_W'(NUM_SRC - 1);
    end else if (write_en) begin
      rr_ptr <= grant;
    end else begin
      rr_ptr <= rr_ptr;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: one fixed-priority and one round-robin instance share
// the same stimulus; a queue-based reference model predicts outputs, a monitor
// compares them each cycle.
module tb_wb_arbiter;
  localparam int NS = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 2;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  typedef struct packed { logic [NS-1:0] rdy; logic [NS-1:0] pend; logic busy; logic we; } stat_t;
  typedef struct packed { logic [31:0] cyc; logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  ent_t  mq [2][NS][$];
  int    rr [2];
  stat_t stat_q [2][$];
  wr_t   wr_q [2][$];

  wb_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW), .ADDR_W(AW)) if0 ();
  wb_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW), .ADDR_W(AW)) if1 ();

  wb_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .ARB_MODE(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  wb_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .ARB_MODE(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: per-source queues, winner chosen from the arbitration rules
  task automatic model_step(input int m, input logic [NS-1:0] v, input logic [NS*AW-1:0] av,
                            input logic [NS*DW-1:0] dv, input logic fl, input logic r);
    stat_t st;
    wr_t   w;
    ent_t  e;
    int    win;
    int    s;
    if (r) begin
      for (int i = 0; i < NS; i++) mq[m][i].delete();
      rr[m] = NS - 1;
      st.rdy = {NS{1'b1}}; st.pend = '0; st.busy = 1'b0; st.we = 1'b0;
      stat_q[m].push_back(st);
    end else begin
      for (int i = 0; i < NS; i++) begin
        st.rdy[i]  = (mq[m][i].size() < DEPTH);
        st.pend[i] = (mq[m][i].size() > 0);
      end
      st.busy = |st.pend;
      st.we   = st.busy && !fl;
      stat_q[m].push_back(st);
      if (fl) begin
        for (int i = 0; i < NS; i++) mq[m][i].delete();
      end else begin
        if (st.we) begin
          win = -1;
          for (int k = 0; k < NS; k++) begin
            s = (m == 0) ? k : (rr[m] + 1 + k) % NS;
            if (win < 0 && st.pend[s]) win = s;
          end
          e = mq[m][win].pop_front();
          w.cyc = cyc; w.a = e.a; w.d = e.d;
          wr_q[m].push_back(w);
          rr[m] = win;
        end
        for (int i = 0; i < NS; i++) begin
          if (v[i] && st.rdy[i] && av[i*AW +: AW] != '0) begin
            e.a = av[i*AW +: AW]; e.d = dv[i*DW +: DW];
            mq[m][i].push_back(e);
          end
        end
      end
    end
  endtask

  // Apply one cycle of stimulus to both instances and record expectations
  task automatic drive(input logic [NS-1:0] v, input logic [NS*AW-1:0] av,
                       input logic [NS*DW-1:0] dv, input logic fl, input logic r);
    @(posedge clk);
    #1;
    rst = r;
    if0.src_valid_i = v; if0.src_waddr_i = av; if0.src_wdata_i = dv; if0.flush_i = fl;
    if1.src_valid_i = v; if1.src_waddr_i = av; if1.src_wdata_i = dv; if1.flush_i = fl;
    model_step(0, v, av, dv, fl, r);
    model_step(1, v, av, dv, fl, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, '0, 1'b0, 1'b0);
  endtask

  // Monitor comparison for one instance
  task automatic check(input int m, input logic [NS-1:0] rdy, input logic [NS-1:0] pend,
                       input logic busy, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    stat_t st;
    wr_t   w;
    if (stat_q[m].size() > 0) begin
      st = stat_q[m].pop_front();
      checks++;
      if ({rdy, pend, busy, we} !== {st.rdy, st.pend, st.busy, st.we}) begin
        errors++;
        $display("FAIL status dut%0d cyc %0d: got rdy=%b pend=%b busy=%b we=%b, expected rdy=%b pend=%b busy=%b we=%b",
                 m, cyc, rdy, pend, busy, we, st.rdy, st.pend, st.busy, st.we);
      end
      checks++;
      if (we) begin
        if (wr_q[m].size() == 0) begin
          errors++;
          $display("FAIL write dut%0d cyc %0d: got x%0d=%h, expected no write", m, cyc, a, d);
        end else begin
          w = wr_q[m].pop_front();
          if (w.cyc !== cyc || w.a !== a || w.d !== d) begin
            errors++;
            $display("FAIL write dut%0d cyc %0d: got x%0d=%h, expected x%0d=%h at cyc %0d",
                     m, cyc, a, d, w.a, w.d, w.cyc);
          end
        end
      end else if (a !== '0 || d !== '0) begin
        errors++;
        $display("FAIL idle_zero dut%0d cyc %0d: got addr=%h data=%h, expected 0", m, cyc, a, d);
      end
    end
  endtask

  always @(negedge clk) begin
    check(0, if0.src_ready_o, if0.pend_o, if0.busy_o, if0.reg_we_o, if0.reg_waddr_o, if0.reg_wdata_o);
    check(1, if1.src_ready_o, if1.pend_o, if1.busy_o, if1.reg_we_o, if1.reg_waddr_o, if1.reg_wdata_o);
  end

  initial begin
    logic [NS*AW-1:0] av;
    logic [NS*DW-1:0] dv;
    logic [NS-1:0]    v;
    if0.src_valid_i = '0; if0.src_waddr_i = '0; if0.src_wdata_i = '0; if0.flush_i = 1'b0;
    if1.src_valid_i = '0; if1.src_waddr_i = '0; if1.src_wdata_i = '0; if1.flush_i = 1'b0;

    drive('0, '0, '0, 1'b0, 1'b1);
    drive('0, '0, '0, 1'b0, 1'b1);
    idle(2);

    // Simultaneous src0 x5=0x11 and src2 x7=0x22
    av = '0; dv = '0;
    av[0*AW +: AW] = 5'd5; dv[0*DW +: DW] = 32'h11;
    av[2*AW +: AW] = 5'd7; dv[2*DW +: DW] = 32'h22;
    drive(4'b0101, av, dv, 1'b0, 1'b0);
    idle(3);

    // Zero destination is accepted but never written
    av = '0; dv = '0;
    av[2*AW +: AW] = 5'd0; dv[2*DW +: DW] = 32'hDEAD;
    drive(4'b0100, av, dv, 1'b0, 1'b0);
    idle(2);

    // All sources valid every cycle
    for (int c = 0; c < 6; c++) begin
      for (int s = 0; s < NS; s++) begin
        av[s*AW +: AW] = AW'(s * 8 + c + 1);
        dv[s*DW +: DW] = 32'h1000 * (s + 1) + 32'(c);
      end
      drive(4'b1111, av, dv, 1'b0, 1'b0);
    end
    idle(14);

    // src0 streams while src1 offers three entries into a two-deep FIFO
    for (int c = 0; c < 6; c++) begin
      av = '0; dv = '0;
      av[0*AW +: AW] = AW'(c + 1);  dv[0*DW +: DW] = 32'hA000 + 32'(c);
      av[1*AW +: AW] = AW'(c + 20); dv[1*DW +: DW] = 32'hB000 + 32'(c);
      drive((c < 3) ? 4'b0011 : 4'b0001, av, dv, 1'b0, 1'b0);
    end
    idle(6);

    // Flush while src1 and src3 are pending
    av = '0; dv = '0;
    av[1*AW +: AW] = 5'd9;  dv[1*DW +: DW] = 32'h99;
    av[3*AW +: AW] = 5'd10; dv[3*DW +: DW] = 32'hAA;
    drive(4'b1010, av, dv, 1'b0, 1'b0);
    drive(4'b1010, av, dv, 1'b1, 1'b0);
    idle(3);

    // Reset while three sources are pending
    av = '0; dv = '0;
    for (int s = 0; s < 3; s++) begin
      av[s*AW +: AW] = AW'(s + 11); dv[s*DW +: DW] = 32'hC0 + 32'(s);
    end
    drive(4'b0111, av, dv, 1'b0, 1'b0);
    drive('0, '0, '0, 1'b0, 1'b1);
    idle(3);

    // Randomized traffic with occasional flush and reset
    for (int c = 0; c < 400; c++) begin
      v = NS'($urandom);
      for (int s = 0; s < NS; s++) begin
        av[s*AW +: AW] = AW'($urandom_range(0, 31));
        dv[s*DW +: DW] = $urandom;
      end
      drive(v, av, dv, ($urandom_range(0, 19) == 0), ($urandom_range(0, 149) == 0));
    end
    idle(16);

    @(negedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (wr_q[m].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d: got %0d writes still expected, expected 0", m, wr_q[m].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
